// File: rtl/core_pkg.sv
// Shared CSR addresses, trap cause codes, mstatus field positions and trap FSM states.
package core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CSR_AW  = 12;
    localparam int unsigned CAUSE_W = 4;

    // Machine-mode CSR addresses
    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

    // Synchronous exception cause codes (interrupt bit 31 is never set)
    localparam logic [CAUSE_W-1:0] CAUSE_INST_ADDR_MIS = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL_INST  = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT    = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_LD_ADDR_MIS   = 4'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_ST_ADDR_MIS   = 4'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M       = 4'd11;

    // mstatus field positions
    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MCAUSE,
        ST_W_MTVAL,
        ST_W_MSTATUS,
        ST_M_STATUS,
        ST_REDIRECT
    } trap_state_t;

endpackage

// File: rtl/trap_cause_enc.sv
// Priority encoder turning write-back exception flags into a cause code and trap value.
module trap_cause_enc
    import core_pkg::*;
(
    input  logic               e_inst_addr_mis_i,
    input  logic               e_illegal_inst_i,
    input  logic               e_ebreak_i,
    input  logic               e_ecall_i,
    input  logic               e_ld_addr_mis_i,
    input  logic               e_st_addr_mis_i,
    input  logic [XLEN-1:0]    instruction_i,
    input  logic [XLEN-1:0]    mem_addr_i,
    input  logic [XLEN-1:0]    target_addr_i,
    output logic               any_exc_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic [XLEN-1:0]    tval_o
);

    // Highest-priority flag selects cause and the value reported in mtval
    always_comb begin
        any_exc_o = e_inst_addr_mis_i | e_illegal_inst_i | e_ebreak_i |
                    e_ecall_i | e_ld_addr_mis_i | e_st_addr_mis_i;
        cause_o   = '0;
        tval_o    = '0;
        if (e_inst_addr_mis_i) begin
            cause_o = CAUSE_INST_ADDR_MIS;
            tval_o  = target_addr_i;
        end else if (e_illegal_inst_i) begin
            cause_o = CAUSE_ILLEGAL_INST;
            tval_o  = instruction_i;
        end else if (e_ebreak_i) begin
            cause_o = CAUSE_BREAKPOINT;
        end else if (e_ecall_i) begin
            cause_o = CAUSE_ECALL_M;
        end else if (e_ld_addr_mis_i) begin
            cause_o = CAUSE_LD_ADDR_MIS;
            tval_o  = mem_addr_i;
        end else if (e_st_addr_mis_i) begin
            cause_o = CAUSE_ST_ADDR_MIS;
            tval_o  = mem_addr_i;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer driving the CSR write port and fetch redirect.
module trap_ctrl
    import core_pkg::*;
#(
    parameter bit         WRITE_MTVAL = 1'b1,
    parameter logic [1:0] MPP_VALUE   = 2'b11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   instruction_i,
    input  logic [XLEN-1:0]   mem_addr_i,
    input  logic [XLEN-1:0]   target_addr_i,
    input  logic              e_inst_addr_mis_i,
    input  logic              e_illegal_inst_i,
    input  logic              e_ebreak_i,
    input  logic              e_ecall_i,
    input  logic              e_ld_addr_mis_i,
    input  logic              e_st_addr_mis_i,
    input  logic              mret_i,
    input  logic [XLEN-1:0]   mstatus_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              wb_kill_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_pc_o
);

    trap_state_t        state, next_state;
    logic               any_exc;
    logic [CAUSE_W-1:0] cause;
    logic [XLEN-1:0]    tval;
    logic               trap, ret;

    // Snapshot taken in the detect cycle; PC-like values keep only word-aligned bits
    logic [XLEN-1:2]    snap_pc;
    logic [CAUSE_W-1:0] snap_cause;
    logic [XLEN-1:0]    snap_tval;
    logic [XLEN-1:0]    snap_mstatus;
    logic [XLEN-1:2]    snap_mtvec;
    logic [XLEN-1:2]    snap_mepc;
    logic               snap_is_ret;

    logic [XLEN-1:0]    mstatus_trap, mstatus_ret;
    logic [5:0]         unused_lsbs;

    assign unused_lsbs = {pc_i[1:0], mtvec_i[1:0], mepc_i[1:0]};

    trap_cause_enc u_cause_enc (
        .e_inst_addr_mis_i (e_inst_addr_mis_i),
        .e_illegal_inst_i  (e_illegal_inst_i),
        .e_ebreak_i        (e_ebreak_i),
        .e_ecall_i         (e_ecall_i),
        .e_ld_addr_mis_i   (e_ld_addr_mis_i),
        .e_st_addr_mis_i   (e_st_addr_mis_i),
        .instruction_i     (instruction_i),
        .mem_addr_i        (mem_addr_i),
        .target_addr_i     (target_addr_i),
        .any_exc_o         (any_exc),
        .cause_o           (cause),
        .tval_o            (tval)
    );

    // Exceptions take precedence over MRET in the same instruction
    assign trap = valid_i & any_exc;
    assign ret  = valid_i & mret_i & ~any_exc;

    // State register and detect-cycle snapshot
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            snap_pc      <= '0;
            snap_cause   <= '0;
            snap_tval    <= '0;
            snap_mstatus <= '0;
            snap_mtvec   <= '0;
            snap_mepc    <= '0;
            snap_is_ret  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && (trap || ret)) begin
                snap_pc      <= pc_i[XLEN-1:2];
                snap_cause   <= cause;
                snap_tval    <= tval;
                snap_mstatus <= mstatus_i;
                snap_mtvec   <= mtvec_i[XLEN-1:2];
                snap_mepc    <= mepc_i[XLEN-1:2];
                snap_is_ret  <= ret;
            end
        end
    end

    // mstatus images for trap entry (stack MIE) and MRET (unstack MPIE)
    always_comb begin
        mstatus_trap                                = snap_mstatus;
        mstatus_trap[MSTATUS_MPIE]                  = snap_mstatus[MSTATUS_MIE];
        mstatus_trap[MSTATUS_MIE]                   = 1'b0;
        mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_VALUE;
        mstatus_ret                                 = snap_mstatus;
        mstatus_ret[MSTATUS_MIE]                    = snap_mstatus[MSTATUS_MPIE];
        mstatus_ret[MSTATUS_MPIE]                   = 1'b1;
        mstatus_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = MPP_VALUE;
    end

    // Next-state and output decode; reset forces every output quiet
    always_comb begin
        next_state    = state;
        csr_we_o      = 1'b0;
        csr_addr_o    = '0;
        csr_wdata_o   = '0;
        wb_kill_o     = 1'b0;
        stall_o       = 1'b0;
        flush_o       = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;

        if (state != ST_IDLE) begin
            stall_o = 1'b1;
            flush_o = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                wb_kill_o = trap | ret;
                flush_o   = trap | ret;
                if (trap)     next_state = ST_W_MEPC;
                else if (ret) next_state = ST_M_STATUS;
            end
            ST_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MEPC;
                csr_wdata_o = {snap_pc, 2'b00};
                next_state  = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MCAUSE;
                csr_wdata_o = XLEN'(snap_cause);
                next_state  = WRITE_MTVAL ? ST_W_MTVAL : ST_W_MSTATUS;
            end
            ST_W_MTVAL: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MTVAL;
                csr_wdata_o = snap_tval;
                next_state  = ST_W_MSTATUS;
            end
            ST_W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MSTATUS;
                csr_wdata_o = mstatus_trap;
                next_state  = ST_REDIRECT;
            end
            ST_M_STATUS: begin
                csr_we_o    = 1'b1;
                csr_addr_o  = CSR_MSTATUS;
                csr_wdata_o = mstatus_ret;
                next_state  = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_o    = 1'b1;
                redirect_pc_o = snap_is_ret ? {snap_mepc, 2'b00} : {snap_mtvec, 2'b00};
                next_state    = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase

        if (rst_i) begin
            csr_we_o      = 1'b0;
            csr_addr_o    = '0;
            csr_wdata_o   = '0;
            wb_kill_o     = 1'b0;
            stall_o       = 1'b0;
            flush_o       = 1'b0;
            redirect_o    = 1'b0;
            redirect_pc_o = '0;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: default build (dut0) alongside a WRITE_MTVAL=0 build (dut1).
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] pc_i, instruction_i, mem_addr_i, target_addr_i;
    logic        e_inst_addr_mis_i, e_illegal_inst_i, e_ebreak_i, e_ecall_i;
    logic        e_ld_addr_mis_i, e_st_addr_mis_i, mret_i;
    logic [31:0] mstatus_i, mtvec_i, mepc_i;

    logic        we0, kill0, stall0, flush0, redir0;
    logic [11:0] addr0;
    logic [31:0] wdata0, rpc0;
    logic        we1, kill1, stall1, flush1, redir1;
    logic [11:0] addr1;
    logic [31:0] wdata1, rpc1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Output bundle: {we, addr, wdata, kill, stall, flush, redirect, redirect_pc}
    wire [80:0] obs0 = {we0, addr0, wdata0, kill0, stall0, flush0, redir0, rpc0};
    wire [80:0] obs1 = {we1, addr1, wdata1, kill1, stall1, flush1, redir1, rpc1};

    trap_ctrl #(.WRITE_MTVAL(1'b1), .MPP_VALUE(2'b11)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
        .instruction_i(instruction_i), .mem_addr_i(mem_addr_i), .target_addr_i(target_addr_i),
        .e_inst_addr_mis_i(e_inst_addr_mis_i), .e_illegal_inst_i(e_illegal_inst_i),
        .e_ebreak_i(e_ebreak_i), .e_ecall_i(e_ecall_i),
        .e_ld_addr_mis_i(e_ld_addr_mis_i), .e_st_addr_mis_i(e_st_addr_mis_i),
        .mret_i(mret_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_we_o(we0), .csr_addr_o(addr0), .csr_wdata_o(wdata0), .wb_kill_o(kill0),
        .stall_o(stall0), .flush_o(flush0), .redirect_o(redir0), .redirect_pc_o(rpc0)
    );

    trap_ctrl #(.WRITE_MTVAL(1'b0), .MPP_VALUE(2'b11)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
        .instruction_i(instruction_i), .mem_addr_i(mem_addr_i), .target_addr_i(target_addr_i),
        .e_inst_addr_mis_i(e_inst_addr_mis_i), .e_illegal_inst_i(e_illegal_inst_i),
        .e_ebreak_i(e_ebreak_i), .e_ecall_i(e_ecall_i),
        .e_ld_addr_mis_i(e_ld_addr_mis_i), .e_st_addr_mis_i(e_st_addr_mis_i),
        .mret_i(mret_i), .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_we_o(we1), .csr_addr_o(addr1), .csr_wdata_o(wdata1), .wb_kill_o(kill1),
        .stall_o(stall1), .flush_o(flush1), .redirect_o(redir1), .redirect_pc_o(rpc1)
    );

    function automatic logic [80:0] csr_wr(input logic [11:0] a, input logic [31:0] d);
        return {1'b1, a, d, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
    endfunction

    function automatic logic [80:0] redir(input logic [31:0] pc);
        return {1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, pc};
    endfunction

    localparam logic [80:0] QUIET   = '0;
    localparam logic [80:0] DETECTV = {1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_i = 0; pc_i = 0; instruction_i = 0; mem_addr_i = 0; target_addr_i = 0;
        e_inst_addr_mis_i = 0; e_illegal_inst_i = 0; e_ebreak_i = 0; e_ecall_i = 0;
        e_ld_addr_mis_i = 0; e_st_addr_mis_i = 0; mret_i = 0;
        mstatus_i = 0; mtvec_i = 0; mepc_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1;
        step(); step();
        if (obs0 !== QUIET) begin nerr++; $display("FAIL reset_dut0: got %h want %h", obs0, QUIET); end
        nvec++;
        rst_i = 0;
        #1;
        if (obs1 !== QUIET) begin nerr++; $display("FAIL reset_dut1: got %h want %h", obs1, QUIET); end
        nvec++;
    endtask

    task automatic test_illegal();
        logic [80:0] exp0 [6];
        exp0[0] = csr_wr(12'h341, 32'h0000_0100);
        exp0[1] = csr_wr(12'h342, 32'd2);
        exp0[2] = csr_wr(12'h343, 32'hFFFF_FFFF);
        exp0[3] = csr_wr(12'h300, 32'h0000_1880);
        exp0[4] = redir(32'h0000_0200);
        exp0[5] = QUIET;
        valid_i = 1; pc_i = 32'h100; instruction_i = 32'hFFFF_FFFF; e_illegal_inst_i = 1;
        mstatus_i = 32'h8; mtvec_i = 32'h0000_0201;
        #1;
        if (obs0 !== DETECTV) begin nerr++; $display("FAIL illegal_T: got %h want %h", obs0, DETECTV); end
        nvec++;
        step();
        clear_inputs();
        mstatus_i = 32'hDEAD_BEEF; mtvec_i = 32'h1234_5678;
        for (int i = 0; i < 6; i++) begin
            if (obs0 !== exp0[i]) begin
                nerr++; $display("FAIL illegal_T+%0d: got %h want %h", i + 1, obs0, exp0[i]);
            end
            nvec++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_priority_no_mtval();
        logic [80:0] exp0 [6];
        logic [80:0] exp1 [6];
        exp0[0] = csr_wr(12'h341, 32'h0000_0200);
        exp0[1] = csr_wr(12'h342, 32'd11);
        exp0[2] = csr_wr(12'h343, 32'h0);
        exp0[3] = csr_wr(12'h300, 32'h0000_1800);
        exp0[4] = redir(32'h0000_0300);
        exp0[5] = QUIET;
        exp1[0] = csr_wr(12'h341, 32'h0000_0200);
        exp1[1] = csr_wr(12'h342, 32'd11);
        exp1[2] = csr_wr(12'h300, 32'h0000_1800);
        exp1[3] = redir(32'h0000_0300);
        exp1[4] = QUIET;
        exp1[5] = QUIET;
        valid_i = 1; pc_i = 32'h202; mem_addr_i = 32'h1003; e_ld_addr_mis_i = 1; e_ecall_i = 1;
        mstatus_i = 32'h0; mtvec_i = 32'h0000_0303;
        #1;
        if (obs1 !== DETECTV) begin nerr++; $display("FAIL ecall_T_dut1: got %h want %h", obs1, DETECTV); end
        nvec++;
        step();
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            if (obs0 !== exp0[i]) begin
                nerr++; $display("FAIL ecall_dut0_T+%0d: got %h want %h", i + 1, obs0, exp0[i]);
            end
            nvec++;
            if (obs1 !== exp1[i]) begin
                nerr++; $display("FAIL ecall_nomtval_T+%0d: got %h want %h", i + 1, obs1, exp1[i]);
            end
            nvec++;
            step();
        end
    endtask

    task automatic test_mret();
        logic [80:0] expv [3];
        expv[0] = csr_wr(12'h300, 32'h0000_1888);
        expv[1] = redir(32'h0000_0104);
        expv[2] = QUIET;
        valid_i = 1; mret_i = 1; pc_i = 32'h400; mstatus_i = 32'h1880; mepc_i = 32'h104;
        mtvec_i = 32'h0000_0200;
        #1;
        if (obs0 !== DETECTV) begin nerr++; $display("FAIL mret_T: got %h want %h", obs0, DETECTV); end
        nvec++;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            if (obs0 !== expv[i]) begin
                nerr++; $display("FAIL mret_T+%0d: got %h want %h", i + 1, obs0, expv[i]);
            end
            nvec++;
            if (obs1 !== expv[i]) begin
                nerr++; $display("FAIL mret_dut1_T+%0d: got %h want %h", i + 1, obs1, expv[i]);
            end
            nvec++;
            step();
        end
    endtask

    task automatic test_mret_with_exc();
        logic [80:0] exp0 [5];
        exp0[0] = csr_wr(12'h341, 32'h0000_0040);
        exp0[1] = csr_wr(12'h342, 32'd2);
        exp0[2] = csr_wr(12'h343, 32'h3020_0073);
        exp0[3] = csr_wr(12'h300, 32'h8000_1880);
        exp0[4] = redir(32'h0000_0080);
        valid_i = 1; mret_i = 1; e_illegal_inst_i = 1; pc_i = 32'h40; instruction_i = 32'h3020_0073;
        mstatus_i = 32'h8000_0008; mtvec_i = 32'h80; mepc_i = 32'h999;
        step();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            if (obs0 !== exp0[i]) begin
                nerr++; $display("FAIL mret_exc_T+%0d: got %h want %h", i + 1, obs0, exp0[i]);
            end
            nvec++;
            step();
        end
        step();
    endtask

    task automatic test_reset_mid();
        valid_i = 1; e_ecall_i = 1; pc_i = 32'h10; mtvec_i = 32'h400;
        step();
        clear_inputs();
        step();
        if (obs0 !== csr_wr(12'h342, 32'd11)) begin
            nerr++; $display("FAIL rst_mid_mcause: got %h want %h", obs0, csr_wr(12'h342, 32'd11));
        end
        nvec++;
        rst_i = 1;
        step();
        rst_i = 0;
        for (int i = 0; i < 5; i++) begin
            if (obs0 !== QUIET) begin
                nerr++; $display("FAIL rst_mid_quiet_%0d: got %h want %h", i, obs0, QUIET);
            end
            nvec++;
            step();
        end
    endtask

    task automatic test_invalid_flags();
        valid_i = 0; e_illegal_inst_i = 1; e_ecall_i = 1; mret_i = 1; e_st_addr_mis_i = 1;
        pc_i = 32'h700; mtvec_i = 32'h800;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (obs0 !== QUIET || obs1 !== QUIET) begin
                nerr++; $display("FAIL invalid_flags_%0d: got %h/%h want %h", i, obs0, obs1, QUIET);
            end
            nvec++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        valid_i = 1; mret_i = 1; mstatus_i = 32'h80; mepc_i = 32'h0000_0105;
        step();
        clear_inputs();
        step();
        valid_i = 1; e_ecall_i = 1; pc_i = 32'h500; mtvec_i = 32'h600;
        #1;
        if (obs0 !== redir(32'h0000_0104)) begin
            nerr++; $display("FAIL b2b_redirect: got %h want %h", obs0, redir(32'h0000_0104));
        end
        nvec++;
        step();
        if (obs0 !== DETECTV) begin nerr++; $display("FAIL b2b_detect: got %h want %h", obs0, DETECTV); end
        nvec++;
        step();
        clear_inputs();
        if (obs0 !== csr_wr(12'h341, 32'h500)) begin
            nerr++; $display("FAIL b2b_mepc: got %h want %h", obs0, csr_wr(12'h341, 32'h500));
        end
        nvec++;
        for (int i = 0; i < 6; i++) step();
        if (obs0 !== QUIET) begin nerr++; $display("FAIL b2b_drain: got %h want %h", obs0, QUIET); end
        nvec++;
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_priority_no_mtval();
        test_mret();
        test_mret_with_exc();
        test_reset_mid();
        test_invalid_flags();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry and MRET return for the core.
- Sits beside the write-back stage and drives the CSR file's single write port.
- On a write-back instruction that carries an exception, it suppresses that instruction's register write, holds and flushes the pipeline, and writes mepc, mcause, mtval and mstatus one per cycle.
- It then redirects fetch to mtvec. On MRET it restores mstatus and redirects fetch to mepc.

Parameters:
- WRITE_MTVAL, 1: when 0, the W_MTVAL state is skipped and mtval is never written.
- MPP_VALUE, 2'b11: privilege value written to mstatus.MPP on both trap entry and MRET. The core is M-only.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  write-back slot holds a valid instruction
- pc_i  in  32  PC of the write-back instruction
- instruction_i  in  32  raw encoding of the write-back instruction
- mem_addr_i  in  32  effective load/store address
- target_addr_i  in  32  misaligned jump/branch target
- e_inst_addr_mis_i, e_illegal_inst_i, e_ebreak_i, e_ecall_i, e_ld_addr_mis_i, e_st_addr_mis_i  in  1 each  exception flags
- mret_i  in  1  write-back instruction is MRET
- mstatus_i, mtvec_i, mepc_i  in  32 each  current CSR values
- csr_we_o  out  1  CSR write strobe
- csr_addr_o  out  12  CSR write address
- csr_wdata_o  out  32  CSR write data
- wb_kill_o  out  1  suppress write-back register-file and CSR writes this cycle
- stall_o  out  1  freeze all pipeline stages
- flush_o  out  1  invalidate IF..MEM
- redirect_o  out  1  one-cycle fetch redirect strobe
- redirect_pc_o  out  32  redirect target

Behaviour:
- Reset: state IDLE. All outputs are 0 and the internal snapshot registers are cleared. Reset asserted in any state returns to IDLE next edge; no further CSR write or redirect occurs.
- Trap detect is combinational in IDLE: trap = valid_i & any exception flag. Return detect: ret = valid_i & mret_i & ~any exception flag. Exceptions always win over MRET.
- Cause priority, highest first:
  - inst_addr_mis = 0
  - illegal = 2
  - ebreak = 3
  - ecall = 11
  - ld_mis = 4
  - st_mis = 6
- mcause bit 31 is always 0.
- mtval by cause:
  - inst_addr_mis → target_addr_i
  - illegal → instruction_i
  - ld/st_mis → mem_addr_i
  - ecall/ebreak → 0
- Cycle T (IDLE with trap or ret):
  - wb_kill_o=1 combinationally.
  - Latch pc, cause, tval, mstatus_i, mtvec_i and mepc_i into snapshot registers.
  - Go to W_MEPC on trap, or M_STATUS on ret.
- FSM and the CSR write each state performs:
  - W_MEPC: mepc ← {pc[31:2],2'b00}
  - W_MCAUSE: mcause ← cause
  - W_MTVAL: mtval ← tval (skipped when WRITE_MTVAL=0)
  - W_MSTATUS: MPIE(bit7) ← snapshot MIE(bit3); MIE ← 0; MPP(12:11) ← MPP_VALUE; other bits unchanged
  - then REDIRECT
- MRET path:
  - M_STATUS: MIE ← snapshot MPIE; MPIE ← 1; MPP ← MPP_VALUE; then REDIRECT.
- REDIRECT:
  - redirect_o=1 for exactly one cycle.
  - Target: {mtvec[31:2],2'b00} for a trap (direct base; mtvec mode bits are ignored), or {mepc[31:2],2'b00} for MRET, both taken from the snapshot.
  - Next state: IDLE.
- csr_we_o=1 in exactly the write states; csr_addr_o and csr_wdata_o are 0 otherwise.
- stall_o=1 and flush_o=1 in every non-IDLE state, including REDIRECT. In IDLE, flush_o=trap|ret (same cycle as T); stall_o=0.
- Latency: trap → redirect at T+5 (T+4 when WRITE_MTVAL=0). MRET → redirect at T+2.
- First new instruction reaches fetch at T+6 for a trap.
- Inputs in non-IDLE states are ignored. A trap arriving in IDLE the same cycle that REDIRECT exits cannot occur, because the pipeline is flushed; if it does occur, the trap is still taken normally.
- A nested exception during the sequence is impossible (stall); no detection is required.

Decomposition:
- core_pkg holds:
  - CSR addresses: MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342, MTVAL 12'h343
  - cause-code constants
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11
  - trap_state_t enum
- Sub-module trap_cause_enc: combinational priority encoder producing any_exc, cause[3:0] and tval[31:0]. The write-back stage reuses it.

Test Plan:
- Illegal instruction 32'hFFFFFFFF at pc 32'h0000_0100, mstatus 32'h8, mtvec 32'h0000_0201:
  - wb_kill at T.
  - Writes in order: 341←0x100, 342←2, 343←0xFFFFFFFF, 300←0x1880.
  - redirect_pc 0x200 at T+5; stall high T+1..T+5.
- Load misaligned at mem_addr 0x1003 together with valid ecall flag → cause 11, mtval 0; priority honored.
- MRET with mstatus 0x1880 and mepc 0x104 → 300←0x1888 at T+1, redirect to 0x104 at T+2, no mepc/mcause write.
- MRET with illegal flag set → trap path taken with cause 2; no M_STATUS restore.
- rst_i asserted in W_MCAUSE → next cycle IDLE, all outputs 0, no redirect, no further csr_we_o.
- WRITE_MTVAL=0 and ecall → no write to 343, redirect at T+4; valid_i=0 with flags set → no action.
